// File: rtl/i2c_bus_conditioner.sv
// I2C pad front end: per-line metastability synchronizer and run-length
// deglitch filter, registered edge strobes, START/STOP detection and a
// bus-busy tracker with an optional idle timeout.
//
// Strobe timing: every strobe (edges, START, STOP) is registered on the same
// clock edge as the filtered level it describes. A strobe is high in exactly
// the first cycle in which SDA_sync/SCL_sync shows the new value.
//
// bus_busy is the FSM state itself (IDLE=0, BUSY=1). It changes on the edge
// after the START/STOP strobe cycle.
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_DEPTH = 3,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 SDA_in,
    input  logic                 SCL_in,
    input  logic [TIMEOUT_W-1:0] bus_free_count,
    output logic                 SDA_sync,
    output logic                 SCL_sync,
    output logic                 SDA_rise,
    output logic                 SDA_fall,
    output logic                 SCL_rise,
    output logic                 SCL_fall,
    output logic                 start_detect,
    output logic                 stop_detect,
    output logic                 bus_busy
);

    localparam int CNT_W = $clog2(FILTER_DEPTH + 1);
    localparam logic [CNT_W-1:0] FLIP_AT = CNT_W'(FILTER_DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sda_meta;
    logic [SYNC_STAGES-1:0] scl_meta;
    logic                   sda_s;
    logic                   scl_s;

    logic [CNT_W-1:0]       sda_cnt;
    logic [CNT_W-1:0]       scl_cnt;
    logic [CNT_W-1:0]       sda_cnt_next;
    logic [CNT_W-1:0]       scl_cnt_next;
    logic                   sda_filt_next;
    logic                   scl_filt_next;

    logic                   sda_rise_next;
    logic                   sda_fall_next;
    logic                   scl_rise_next;
    logic                   scl_fall_next;
    logic                   start_next;
    logic                   stop_next;

    state_t                 state;
    state_t                 state_next;
    logic                   timeout;
    logic [TIMEOUT_W-1:0]   idle_cnt;

    assign sda_s = sda_meta[SYNC_STAGES-1];
    assign scl_s = scl_meta[SYNC_STAGES-1];

    // Synchronizer chains; reset to the idle-bus level (high).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_meta <= '1;
            scl_meta <= '1;
        end else begin
            sda_meta <= {sda_meta[SYNC_STAGES-2:0], SDA_in};
            scl_meta <= {scl_meta[SYNC_STAGES-2:0], SCL_in};
        end
    end

    // Filter next state: count consecutive disagreeing samples, flip on the
    // FILTER_DEPTH-th one and clear the count on that same edge.
    always_comb begin
        sda_cnt_next  = '0;
        sda_filt_next = SDA_sync;
        if (sda_s != SDA_sync) begin
            if (sda_cnt == FLIP_AT) begin
                sda_filt_next = ~SDA_sync;
            end else begin
                sda_cnt_next = sda_cnt + CNT_W'(1);
            end
        end
    end

    // Same filter rule for SCL.
    always_comb begin
        scl_cnt_next  = '0;
        scl_filt_next = SCL_sync;
        if (scl_s != SCL_sync) begin
            if (scl_cnt == FLIP_AT) begin
                scl_filt_next = ~SCL_sync;
            end else begin
                scl_cnt_next = scl_cnt + CNT_W'(1);
            end
        end
    end

    // Strobe decode from current vs next filtered levels. START/STOP need SCL
    // high both before and after this edge, which excludes a same-cycle SCL edge.
    always_comb begin
        sda_rise_next = ~SDA_sync & sda_filt_next;
        sda_fall_next = SDA_sync & ~sda_filt_next;
        scl_rise_next = ~SCL_sync & scl_filt_next;
        scl_fall_next = SCL_sync & ~scl_filt_next;
        start_next    = sda_fall_next & SCL_sync & scl_filt_next;
        stop_next     = sda_rise_next & SCL_sync & scl_filt_next;
    end

    // Filtered levels, filter counters and strobes, all registered together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_cnt      <= '0;
            scl_cnt      <= '0;
            SDA_sync     <= 1'b1;
            SCL_sync     <= 1'b1;
            SDA_rise     <= 1'b0;
            SDA_fall     <= 1'b0;
            SCL_rise     <= 1'b0;
            SCL_fall     <= 1'b0;
            start_detect <= 1'b0;
            stop_detect  <= 1'b0;
        end else begin
            sda_cnt      <= sda_cnt_next;
            scl_cnt      <= scl_cnt_next;
            SDA_sync     <= sda_filt_next;
            SCL_sync     <= scl_filt_next;
            SDA_rise     <= sda_rise_next;
            SDA_fall     <= sda_fall_next;
            SCL_rise     <= scl_rise_next;
            SCL_fall     <= scl_fall_next;
            start_detect <= start_next;
            stop_detect  <= stop_next;
        end
    end

    // Timeout compares the live threshold, so a new bus_free_count applies at once.
    assign timeout = (state == ST_BUSY) && (bus_free_count != '0) &&
                     (idle_cnt == bus_free_count);

    // Bus state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus state transitions; a repeated START in BUSY simply stays in BUSY.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_detect) state_next = ST_BUSY;
            ST_BUSY: if (stop_detect || timeout) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus state output.
    always_comb begin
        bus_busy = (state == ST_BUSY);
    end

    // Idle counter: counts both-high cycles while staying in BUSY, saturating;
    // cleared by a low line, while IDLE, and on entry to or exit from BUSY.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_cnt <= '0;
        end else if (state == ST_BUSY && state_next == ST_BUSY) begin
            if (SDA_sync && SCL_sync) begin
                if (idle_cnt != '1) idle_cnt <= idle_cnt + TIMEOUT_W'(1);
            end else begin
                idle_cnt <= '0;
            end
        end else begin
            idle_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner. Outputs are packed as
// {SDA_sync, SCL_sync, SDA_rise, SDA_fall, SCL_rise, SCL_fall,
//  start_detect, stop_detect, bus_busy}.
// The driver changes pads at negedge and pushes the predicted output vector
// for the following posedge. The monitor pops one entry per posedge (+1).
module tb_i2c_bus_conditioner;

    localparam int SYNC_STAGES  = 2;
    localparam int FILTER_DEPTH = 3;
    localparam int TIMEOUT_W    = 16;
    localparam logic [8:0] RESET_VEC = 9'b1_1000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 SDA_in;
    logic                 SCL_in;
    logic [TIMEOUT_W-1:0] bus_free_count;
    logic SDA_sync, SCL_sync, SDA_rise, SDA_fall, SCL_rise, SCL_fall;
    logic start_detect, stop_detect, bus_busy;
    logic [8:0] dut_out;

    always #5 clk = ~clk;

    i2c_bus_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_DEPTH(FILTER_DEPTH),
        .TIMEOUT_W   (TIMEOUT_W)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .SDA_in        (SDA_in),
        .SCL_in        (SCL_in),
        .bus_free_count(bus_free_count),
        .SDA_sync      (SDA_sync),
        .SCL_sync      (SCL_sync),
        .SDA_rise      (SDA_rise),
        .SDA_fall      (SDA_fall),
        .SCL_rise      (SCL_rise),
        .SCL_fall      (SCL_fall),
        .start_detect  (start_detect),
        .stop_detect   (stop_detect),
        .bus_busy      (bus_busy)
    );

    assign dut_out = {SDA_sync, SCL_sync, SDA_rise, SDA_fall, SCL_rise, SCL_fall,
                      start_detect, stop_detect, bus_busy};

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Pads pass through a pure delay line; the filter flips a line when its
    // last FILTER_DEPTH delayed samples (since reset) all disagree with it.
    bit   sda_dly[$];
    bit   scl_dly[$];
    bit   sda_win[$];
    bit   scl_win[$];
    bit   m_sda_f, m_scl_f, m_busy;
    int   m_run;
    logic [8:0] m_out;
    bit   last_r;
    logic [TIMEOUT_W-1:0] next_bfc;

    function automatic bit flips(input bit w[$], input bit cur);
        if (w.size() < FILTER_DEPTH) return 1'b0;
        foreach (w[i]) if (w[i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        sda_dly = {};
        scl_dly = {};
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sda_dly.push_back(1'b1);
            scl_dly.push_back(1'b1);
        end
        sda_win = {};
        scl_win = {};
        m_sda_f = 1'b1;
        m_scl_f = 1'b1;
        m_busy  = 1'b0;
        m_run   = 0;
        m_out   = RESET_VEC;
    endtask

    task automatic model_edge(input bit pad_sda, input bit pad_scl, input int bfc);
        bit s_sda, s_scl, n_sda, n_scl;
        bit sr, sf, cr, cf, st, sp, timeout, nb;
        bit p_start, p_stop;
        s_sda = sda_dly[$];
        s_scl = scl_dly[$];
        void'(sda_dly.pop_back());
        void'(scl_dly.pop_back());
        sda_dly.push_front(pad_sda);
        scl_dly.push_front(pad_scl);
        sda_win.push_back(s_sda);
        scl_win.push_back(s_scl);
        if (sda_win.size() > FILTER_DEPTH) void'(sda_win.pop_front());
        if (scl_win.size() > FILTER_DEPTH) void'(scl_win.pop_front());
        n_sda = flips(sda_win, m_sda_f) ? !m_sda_f : m_sda_f;
        n_scl = flips(scl_win, m_scl_f) ? !m_scl_f : m_scl_f;
        sr = !m_sda_f && n_sda;
        sf = m_sda_f && !n_sda;
        cr = !m_scl_f && n_scl;
        cf = m_scl_f && !n_scl;
        st = sf && m_scl_f && n_scl;
        sp = sr && m_scl_f && n_scl;
        p_start = m_out[2];
        p_stop  = m_out[1];
        timeout = m_busy && (bfc != 0) && (m_run == bfc);
        nb      = m_busy ? !(p_stop || timeout) : p_start;
        m_run   = (m_busy && nb && m_sda_f && m_scl_f) ? m_run + 1 : 0;
        m_busy  = nb;
        m_sda_f = n_sda;
        m_scl_f = n_scl;
        m_out   = {n_sda, n_scl, sr, sf, cr, cf, st, sp, nb};
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit sda, input bit scl);
        @(negedge clk);
        SDA_in         = sda;
        SCL_in         = scl;
        bus_free_count = next_bfc;
        if (!r) begin
            n_rst = 1'b0;
            model_reset();
            exp_q.push_back(m_out);
            if (last_r) begin
                #1;
                checks++;
                if (dut_out !== RESET_VEC) begin
                    errors++;
                    $display("FAIL async_reset t=%0t: got %b want %b", $time, dut_out, RESET_VEC);
                end
            end
        end else begin
            n_rst = 1'b1;
            model_edge(sda, scl, int'(next_bfc));
            exp_q.push_back(m_out);
        end
        last_r = r;
    endtask

    task automatic run(input bit sda, input bit scl, input int n);
        repeat (n) step(1'b1, sda, scl);
    endtask

    task automatic hold_reset(input bit sda, input bit scl, input int n);
        repeat (n) step(1'b0, sda, scl);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (dut_out !== mon_exp) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got %b want %b", $time, dut_out, mon_exp);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit   rs, rc;
        int   len;
        n_rst          = 1'b1;
        SDA_in         = 1'b0;
        SCL_in         = 1'b0;
        bus_free_count = '0;
        next_bfc       = '0;
        last_r         = 1'b0;
        model_reset();

        // Reset with pads low: outputs at reset values immediately.
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (dut_out !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", dut_out, RESET_VEC);
        end
        hold_reset(1'b0, 1'b0, 4);

        // Release with pads low: both lines fall together on edge 5, no START.
        run(1'b0, 1'b0, 10);
        run(1'b1, 1'b1, 10);

        // SCL glitches: 2-cycle low is rejected, 3-cycle low passes.
        run(1'b1, 1'b0, 2);
        run(1'b1, 1'b1, 10);
        run(1'b1, 1'b0, 3);
        run(1'b1, 1'b1, 10);

        // START then STOP.
        run(1'b0, 1'b1, 10);
        run(1'b1, 1'b1, 10);

        // Both lines fall on the same clock: no START.
        run(1'b0, 1'b0, 10);
        run(1'b1, 1'b1, 10);

        // Repeated START, then idle-high with timeout 10.
        run(1'b0, 1'b1, 8);
        run(1'b0, 1'b0, 8);
        run(1'b1, 1'b0, 8);
        run(1'b1, 1'b1, 8);
        run(1'b0, 1'b1, 8);
        run(1'b0, 1'b0, 8);
        run(1'b1, 1'b0, 8);
        next_bfc = 16'd10;
        run(1'b1, 1'b1, 25);

        // Same again with the timeout disabled: bus stays busy, then STOP.
        next_bfc = 16'd0;
        run(1'b0, 1'b1, 8);
        run(1'b0, 1'b0, 8);
        run(1'b1, 1'b0, 8);
        run(1'b1, 1'b1, 40);
        run(1'b1, 1'b0, 8);
        run(1'b0, 1'b0, 8);
        run(1'b0, 1'b1, 8);
        run(1'b1, 1'b1, 10);

        // Reset mid-transfer while busy with SDA low.
        run(1'b0, 1'b1, 10);
        hold_reset(1'b0, 1'b1, 3);
        run(1'b1, 1'b1, 10);

        // Randomized segments.
        for (int seg = 0; seg < 350; seg++) begin
            if ($urandom_range(0, 9) == 0)
                next_bfc = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 30));
            if ($urandom_range(0, 59) == 0) begin
                hold_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
            end else if ($urandom_range(0, 19) == 0) begin
                run(1'b1, 1'b1, $urandom_range(20, 45));
            end else begin
                rs  = 1'($urandom_range(0, 1));
                rc  = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 8);
                run(rs, rc, len);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
